// File: rtl/pulse_burst_rx.sv
// Receive-side decoder for the pulse-burst line: synchronise, glitch-filter,
// count filtered rising edges and report the count once the line has stayed low for a full gap.
module pulse_burst_rx #(
  parameter int CNT_W       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 16,
  parameter int GAP_CYCLES  = 262144
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in,
  output logic [CNT_W-1:0] count,
  output logic             valid,
  output logic             overflow,
  output logic             busy
);

  localparam int STAB_W = $clog2(FILT_LEN + 1);
  localparam int GAP_W  = $clog2(GAP_CYCLES + 1);
  localparam int PCNT_W = CNT_W + 1;

  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(FILT_LEN - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYCLES);

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  logic [SYNC_STAGES-1:0] r_sync;
  logic [STAB_W-1:0]      r_stab;
  logic                   r_f;
  logic [PCNT_W-1:0]      r_pulses;
  logic [GAP_W-1:0]       r_gap;
  state_t                 r_state;

  logic w_s;
  logic w_stab_hit;
  logic w_f_nxt;
  logic w_rise;

  // Pulse counter stops at 2^CNT_W; that value alone marks overflow.
  function automatic logic [PCNT_W-1:0] sat_inc(input logic [PCNT_W-1:0] p);
    return p[CNT_W] ? p : p + PCNT_W'(1);
  endfunction

  function automatic logic [CNT_W-1:0] sat_count(input logic [PCNT_W-1:0] p);
    return p[CNT_W] ? {CNT_W{1'b1}} : p[CNT_W-1:0];
  endfunction

  assign w_s        = r_sync[SYNC_STAGES-1];
  assign w_stab_hit = (w_s != r_f) && (r_stab == STAB_LAST);
  assign w_f_nxt    = w_stab_hit ? w_s : r_f;
  // The FSM reacts to the filtered level in the same edge that updates it.
  assign w_rise     = w_f_nxt & ~r_f;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync <= '0;
      r_stab <= '0;
      r_f    <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], in};
      if (w_s == r_f) begin
        r_stab <= '0;
      end else if (w_stab_hit) begin
        r_stab <= '0;
        r_f    <= w_s;
      end else begin
        r_stab <= r_stab + STAB_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= IDLE;
      r_pulses <= '0;
      r_gap    <= '0;
      count    <= '0;
      valid    <= 1'b0;
      overflow <= 1'b0;
      busy     <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_rise) begin
            r_pulses <= PCNT_W'(1);
            busy     <= 1'b1;
            r_state  <= HIGH;
          end
        end
        HIGH: begin
          if (!w_f_nxt) begin
            r_gap   <= GAP_W'(1);
            r_state <= LOW;
          end
        end
        LOW: begin
          // A rise coinciding with gap expiry keeps the burst alive.
          if (w_rise) begin
            r_pulses <= sat_inc(r_pulses);
            r_gap    <= '0;
            r_state  <= HIGH;
          end else if (r_gap == GAP_LAST) begin
            valid    <= 1'b1;
            count    <= sat_count(r_pulses);
            overflow <= r_pulses[CNT_W];
            r_pulses <= '0;
            r_gap    <= '0;
            busy     <= 1'b0;
            r_state  <= IDLE;
          end else begin
            r_gap <= r_gap + GAP_W'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pulse_burst_rx.sv
// Randomised scoreboard bench for pulse_burst_rx: the line is described as pulses of
// given high/low lengths and the expected reports come from burst-splitting rules on those lengths.
module tb_pulse_burst_rx;

  localparam int CNT_W = 4;
  localparam int SYNC  = 2;
  localparam int FILT  = 3;
  localparam int GAP   = 20;
  localparam int MAXC  = (1 << CNT_W) - 1;
  localparam int LAT   = SYNC + FILT;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             in = 1'b0;
  logic [CNT_W-1:0] count;
  logic             valid;
  logic             overflow;
  logic             busy;

  pulse_burst_rx #(
    .CNT_W(CNT_W), .SYNC_STAGES(SYNC), .FILT_LEN(FILT), .GAP_CYCLES(GAP)
  ) dut (
    .clk(clk), .reset_n(reset_n), .in(in),
    .count(count), .valid(valid), .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cnt;
    bit ovf;
    int at;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   m_pulses = 0;
  int   last_cyc = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every valid must match the oldest expected report.
  exp_t mon_e;
  int   prev_state = 0;
  bit   have_prev = 0;
  always @(negedge clk) begin
    if (reset_n) begin
      if (valid) begin
        chk("report_expected", int'(sbq.size() > 0), 1);
        if (sbq.size() > 0) begin
          mon_e = sbq.pop_front();
          chk("count", int'(count), mon_e.cnt);
          chk("overflow", int'(overflow), int'(mon_e.ovf));
          chk("valid_cycle", cyc, mon_e.at);
          chk("busy_at_valid", int'(busy), 0);
        end
      end else if (have_prev) begin
        chk("count_hold", int'({overflow, count}), prev_state);
      end
    end
    prev_state = int'({overflow, count});
    have_prev  = reset_n;
  end

  task automatic seg(input logic lv, input int n);
    @(posedge clk);
    #1;
    in = lv;
    last_cyc = cyc;
    repeat (n - 1) @(posedge clk);
  endtask

  // Falling edge and low time of a pulse; a low run longer than GAP closes the burst.
  task automatic pulse_tail(input int l, input bit g);
    exp_t e;
    seg(1'b0, 1);
    m_pulses++;
    if (l > GAP) begin
      e.cnt = (m_pulses > MAXC) ? MAXC : m_pulses;
      e.ovf = (m_pulses > MAXC);
      e.at  = last_cyc + LAT + GAP;
      sbq.push_back(e);
      m_pulses = 0;
    end
    if (g) begin
      seg(1'b0, 3);
      seg(1'b1, 2);
      seg(1'b0, l - 6);
    end else if (l > 1) begin
      seg(1'b0, l - 1);
    end
  endtask

  task automatic pulse(input int h, input int l, input bit g);
    if (g) begin
      seg(1'b1, 3);
      seg(1'b0, 2);
      seg(1'b1, h - 5);
    end else begin
      seg(1'b1, h);
    end
    pulse_tail(l, g);
  endtask

  initial begin
    int t0;
    int np;
    int h;
    int l;
    bit g;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_count", int'(count), 0);
    chk("rst_valid", int'(valid), 0);
    chk("rst_overflow", int'(overflow), 0);
    chk("rst_busy", int'(busy), 0);
    reset_n = 1'b1;
    repeat (3) @(posedge clk);

    // Five pulses; busy timing checked on the first edge.
    @(posedge clk);
    #1;
    in = 1'b1;
    t0 = cyc;
    repeat (4) @(posedge clk);
    #1;
    chk("busy_before_rise", int'(busy), 0);
    @(posedge clk);
    #1;
    chk("busy_after_rise", int'(busy), 1);
    chk("busy_latency", cyc - t0, LAT);
    repeat (4) @(posedge clk);
    pulse_tail(10, 1'b0);
    repeat (3) pulse(10, 10, 1'b0);
    pulse(10, 30, 1'b0);

    // Glitches inside pulses and on the idle line.
    pulse(10, 10, 1'b1);
    pulse(10, 10, 1'b1);
    pulse(10, 30, 1'b1);
    seg(1'b1, 2);
    seg(1'b0, 30);
    #1;
    chk("idle_glitch_busy", int'(busy), 0);

    // Saturation, then a clean small burst.
    repeat (16) pulse(5, 5, 1'b0);
    pulse(5, 30, 1'b0);
    pulse(10, 10, 1'b0);
    pulse(10, 30, 1'b0);

    // Gap lengths around the threshold.
    pulse(10, 10, 1'b0);
    pulse(10, 19, 1'b0);
    pulse(10, 10, 1'b0);
    pulse(10, 30, 1'b0);
    pulse(10, 20, 1'b0);
    pulse(10, 30, 1'b0);
    pulse(10, 21, 1'b0);
    pulse(10, 30, 1'b0);
    pulse(10, 10, 1'b0);
    pulse(10, 25, 1'b0);
    pulse(10, 10, 1'b0);
    pulse(10, 10, 1'b0);
    pulse(10, 30, 1'b0);

    // Line stuck high: no report until it finally falls.
    seg(1'b1, 80);
    #1;
    chk("stuck_high_busy", int'(busy), 1);
    pulse_tail(30, 1'b0);

    // Reset in the middle of pulse 3 of 6 discards the burst.
    pulse(10, 10, 1'b0);
    pulse(10, 10, 1'b0);
    seg(1'b1, 4);
    @(posedge clk);
    #1;
    chk("busy_mid_burst", int'(busy), 1);
    reset_n = 1'b0;
    in = 1'b0;
    m_pulses = 0;
    #1;
    chk("midrst_count", int'(count), 0);
    chk("midrst_valid", int'(valid), 0);
    chk("midrst_overflow", int'(overflow), 0);
    chk("midrst_busy", int'(busy), 0);
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    seg(1'b0, 40);
    pulse(10, 30, 1'b0);

    // Randomised bursts; inner gaps may exceed the threshold and split a burst.
    for (int b = 0; b < 6; b++) begin
      np = $urandom_range(18, 1);
      for (int p = 0; p < np; p++) begin
        h = $urandom_range(12, 3);
        l = (p == np - 1) ? $urandom_range(30, 21) : $urandom_range(24, 3);
        g = (h >= 8 && l >= 9) ? 1'($urandom_range(1, 0)) : 1'b0;
        pulse(h, l, g);
      end
    end

    repeat (40) @(posedge clk);
    #1;
    chk("scoreboard_drained", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout actual=%0d expected=finished", cyc);
    $fatal(1, "timeout");
  end

endmodule
